// File: rtl/cmsdk_mcu_rst_pclken_ctrl.sv
// cmsdk_mcu_rst_pclken_ctrl: reset sequencer with stretched HRESETn/PRESETn, APB clock-enable divider and sticky reset cause
module cmsdk_mcu_rst_pclken_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int CNT_W      = 8,
    parameter int RST_CYCLES = 16,
    parameter int DIV_W      = 3
) (
    input  logic               FCLK,
    input  logic               PORESETn,
    input  logic [NUM_REQ-1:0] RESETREQ,
    input  logic [NUM_REQ-1:0] REQMASK,
    input  logic               LOCKUP,
    input  logic               LOCKUPRESET,
    input  logic [DIV_W-1:0]   PCLKDIV,
    input  logic               CAUSE_CLR,
    output logic               HRESETn,
    output logic               PRESETn,
    output logic               PCLKEN,
    output logic [NUM_REQ+1:0] RSTCAUSE,
    output logic               RSTACTIVE
);
    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] PREL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RST_CYCLES - 1);

    logic [1:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [DIV_W-1:0]   div_cnt, div_q;
    logic [NUM_REQ-1:0] req_vec;
    logic               lock_req, req;

    assign req_vec  = RESETREQ & ~REQMASK;
    assign lock_req = LOCKUP & LOCKUPRESET;
    assign req      = |req_vec | lock_req;

    // Any unmasked request (re)starts the stretch from any state; PRESETn waits for a PCLKEN cycle
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (req) begin
            state_d = HOLD;
            cnt_d   = RELOAD;
        end else begin
            case (state)
                HOLD:    if (cnt != '0) cnt_d = cnt - 1'b1; else state_d = PREL;
                PREL:    if (PCLKEN) state_d = RUN;
                RUN:     ;
                default: state_d = HOLD;
            endcase
        end
    end

    // Reset outputs are registered from the next state so they switch with the FSM
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            state     <= HOLD;
            cnt       <= RELOAD;
            HRESETn   <= 1'b0;
            PRESETn   <= 1'b0;
            RSTACTIVE <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            HRESETn   <= state_d != HOLD;
            PRESETn   <= state_d == RUN;
            RSTACTIVE <= state_d != RUN;
        end
    end

    // Divider latches PCLKDIV only at wrap so a new ratio never produces a short period
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            div_cnt <= '0;
            div_q   <= '0;
            PCLKEN  <= 1'b0;
        end else if (div_cnt == div_q) begin
            div_cnt <= '0;
            div_q   <= PCLKDIV;
            PCLKEN  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            PCLKEN  <= 1'b0;
        end
    end

    // Sticky cause: a same-cycle set beats CAUSE_CLR, only power-on reset restores the POR bit
    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn)
            RSTCAUSE <= (NUM_REQ+2)'(1);
        else
            RSTCAUSE <= (CAUSE_CLR ? {(NUM_REQ+2){1'b0}} : RSTCAUSE) | {lock_req, req_vec, 1'b0};
    end
endmodule

// File: tb/tb_cmsdk_mcu_rst_pclken_ctrl.sv
// tb_cmsdk_mcu_rst_pclken_ctrl: directed, table-driven and random checks against a timeline-based reference model
module tb_cmsdk_mcu_rst_pclken_ctrl;
    localparam int RST = 16;

    logic       FCLK = 1'b0;
    logic       PORESETn = 1'b1;
    logic [3:0] RESETREQ = '0;
    logic [3:0] REQMASK = '0;
    logic       LOCKUP = 1'b0;
    logic       LOCKUPRESET = 1'b0;
    logic [2:0] PCLKDIV = 3'd3;
    logic       CAUSE_CLR = 1'b0;
    logic       HRESETn, PRESETn, PCLKEN, RSTACTIVE;
    logic [5:0] RSTCAUSE;

    cmsdk_mcu_rst_pclken_ctrl #(.NUM_REQ(4), .CNT_W(8), .RST_CYCLES(RST), .DIV_W(3)) dut (
        .FCLK(FCLK), .PORESETn(PORESETn), .RESETREQ(RESETREQ), .REQMASK(REQMASK),
        .LOCKUP(LOCKUP), .LOCKUPRESET(LOCKUPRESET), .PCLKDIV(PCLKDIV), .CAUSE_CLR(CAUSE_CLR),
        .HRESETn(HRESETn), .PRESETn(PRESETn), .PCLKEN(PCLKEN), .RSTCAUSE(RSTCAUSE), .RSTACTIVE(RSTACTIVE)
    );

    always #5 FCLK = ~FCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: cycle counter since POR release, time of last request, scheduled PCLKEN pulse
    int         cyc, last_req, next_pulse;
    logic       m_h, m_p, m_pen;
    logic [5:0] m_cause;

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       lk;
        logic       lr;
        logic       clr;
        logic [5:0] cause;
        logic       h;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        last_req = -1;
        next_pulse = 1;
        m_h = 1'b0;
        m_p = 1'b0;
        m_pen = 1'b0;
        m_cause = 6'd1;
    endtask

    // HRESETn is high once more than RST cycles have passed since the last request;
    // PRESETn follows once a PCLKEN has been seen while HRESETn was already high.
    task automatic model_step();
        logic [3:0] rv;
        logic lk, r, h_now, p_now, pen_now;
        rv = RESETREQ & ~REQMASK;
        lk = LOCKUP & LOCKUPRESET;
        r = (rv != 0) || lk;
        h_now = m_h;
        p_now = m_p;
        pen_now = m_pen;
        if (r) last_req = cyc;
        m_h = (cyc + 1 - last_req) > RST;
        m_p = h_now && !r && (p_now || pen_now);
        m_pen = (cyc + 1 == next_pulse);
        if (m_pen) next_pulse = cyc + 2 + int'(PCLKDIV);
        m_cause = (CAUSE_CLR ? 6'd0 : m_cause) | {lk, rv, 1'b0};
        cyc++;
    endtask

    task automatic check_model();
        chk("hresetn", HRESETn, m_h);
        chk("presetn", PRESETn, m_p);
        chk("pclken", PCLKEN, m_pen);
        chk("rstactive", RSTACTIVE, !(m_h && m_p));
        chk("rstcause", RSTCAUSE, m_cause);
    endtask

    task automatic tick();
        model_step();
        @(posedge FCLK);
        #1;
        check_model();
    endtask

    task automatic por();
        PORESETn = 1'b0;
        #1;
        chk("por_async_hresetn", HRESETn, 0);
        chk("por_async_presetn", PRESETn, 0);
        chk("por_async_pclken", PCLKEN, 0);
        chk("por_async_rstactive", RSTACTIVE, 1);
        chk("por_async_rstcause", RSTCAUSE, 6'b000001);
        repeat (2) @(negedge FCLK);
        PORESETn = 1'b1;
        model_reset();
        #1;
        check_model();
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (!(HRESETn === 1'b1 && PRESETn === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_run_in_budget", n < 200, 1);
    endtask

    initial begin
        int n;
        tv[0] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 6'b001000, 1'b0};
        tv[1] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0};
        tv[2] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0};
        tv[3] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0};
        tv[4] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 6'b100000, 1'b0};
        tv[5] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 6'b000010, 1'b0};
        tv[6] = '{4'b1010, 4'b0010, 1'b0, 1'b0, 1'b0, 6'b010010, 1'b0};
        tv[7] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0};

        #3;
        por();
        n = 0;
        while (HRESETn !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("por_hresetn_release_cycle", n, 16);
        while (PRESETn !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("por_presetn_release_cycle", n, 18);
        chk("por_cause", RSTCAUSE, 6'b000001);

        repeat (3) tick();
        RESETREQ = 4'b0100;
        tick();
        RESETREQ = 4'b0000;
        n = 0;
        while (HRESETn === 1'b0 && n < 60) begin
            n++;
            tick();
        end
        chk("single_req_low_cycles", n, 16);
        chk("single_req_cause", RSTCAUSE, 6'b001001);
        CAUSE_CLR = 1'b1;
        tick();
        CAUSE_CLR = 1'b0;
        chk("cause_clear", RSTCAUSE, 6'b000000);

        wait_run();
        RESETREQ = 4'b0001;
        tick();
        RESETREQ = 4'b0000;
        n = 0;
        while (HRESETn === 1'b0 && n < 80) begin
            n++;
            RESETREQ = (n == 10) ? 4'b0001 : 4'b0000;
            tick();
        end
        RESETREQ = 4'b0000;
        chk("stretched_req_low_cycles", n, 26);

        wait_run();
        REQMASK = 4'b0100;
        RESETREQ = 4'b0100;
        repeat (5) tick();
        chk("masked_req_no_reset", HRESETn, 1);
        chk("masked_req_cause", RSTCAUSE, 6'b000010);
        RESETREQ = 4'b0000;
        REQMASK = 4'b0000;
        LOCKUP = 1'b1;
        LOCKUPRESET = 1'b0;
        repeat (4) tick();
        chk("lockup_ignored", HRESETn, 1);
        LOCKUP = 1'b0;
        CAUSE_CLR = 1'b1;
        tick();
        CAUSE_CLR = 1'b0;

        for (int i = 0; i < 8; i++) begin
            RESETREQ = tv[i].req;
            REQMASK = tv[i].mask;
            LOCKUP = tv[i].lk;
            LOCKUPRESET = tv[i].lr;
            CAUSE_CLR = tv[i].clr;
            tick();
            chk($sformatf("vec%0d_cause", i), RSTCAUSE, tv[i].cause);
            chk($sformatf("vec%0d_hresetn", i), HRESETn, tv[i].h);
        end
        RESETREQ = 4'b0000;
        REQMASK = 4'b0000;
        LOCKUP = 1'b0;
        LOCKUPRESET = 1'b0;
        CAUSE_CLR = 1'b0;
        wait_run();

        n = 0;
        while (PCLKEN !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("pclken_sync_in_budget", n < 20, 1);
        tick();
        PCLKDIV = 3'd0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("div_3to0_c%0d", i), PCLKEN, i >= 2);
        end
        PCLKDIV = 3'd7;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (PCLKEN !== 1'b1 && n < 20);
        chk("div7_period", n, 8);

        RESETREQ = 4'b1000;
        tick();
        RESETREQ = 4'b0000;
        repeat (3) tick();
        chk("hold_before_por", HRESETn, 0);
        por();
        n = 0;
        while (HRESETn !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("prel_reached", {HRESETn, PRESETn}, 2'b10);
        por();

        for (int i = 0; i < 1500; i++) begin
            RESETREQ = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            REQMASK = 4'($urandom);
            LOCKUP = ($urandom_range(0, 59) == 0);
            LOCKUPRESET = 1'($urandom_range(0, 1));
            CAUSE_CLR = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) PCLKDIV = 3'($urandom);
            if ($urandom_range(0, 399) == 0) por();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
